// File: rtl/ps2_key_serializer.sv
// Turns hps_io ps2_key events into scancode bytes (E0/F0 prefixes) and shifts
// them out as PS/2 device-to-host frames on an open-drain clock/data pair.
module ps2_key_serializer #(
   parameter int HALF_CYC   = 2000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic        ps2_clk_i,
   input  logic        ps2_data_i,
   output logic        ps2_clk_o,
   output logic        ps2_data_o,
   output logic        busy,
   output logic        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(2 * HALF_CYC + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
   localparam logic [CW-1:0] CHK_LAST  = CW'(2 * HALF_CYC - 1);
   localparam logic [CW-1:0] INH_FIRST = CW'(3);
   localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BUSCHK = 3'd1,
      ST_HIGH   = 3'd2,
      ST_LOW    = 3'd3,
      ST_GAP    = 3'd4,
      ST_ABORT  = 3'd5
   } tx_state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   logic            r_clk_m, r_clk_s, r_dat_m, r_dat_s;
   logic            r_key_prev, r_exp_active, r_pend_e0, r_pend_f0, r_overflow;
   logic [7:0]      r_exp_code;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW:0]     r_wptr, r_rptr;
   tx_state_t       r_state;
   logic [CW-1:0]   r_cnt;
   logic [3:0]      r_bit;
   logic [10:0]     r_frame;
   logic            r_clk_o, r_data_o, r_busy;

   logic            w_event, w_push, w_pop, w_empty, w_busy;
   logic [1:0]      w_need;
   logic [AW:0]     w_count, w_free;
   logic [7:0]      w_push_byte, w_head;
   logic [3:0]      w_next_bit;

   // Occupancy, event detection and the byte the expander emits this cycle.
   always_comb begin
      w_count     = r_wptr - r_rptr;
      w_free      = DEPTH_W - w_count;
      w_empty     = (r_wptr == r_rptr);
      w_head      = r_mem[r_rptr[AW-1:0]];
      w_event     = !r_exp_active && (ps2_key[10] != r_key_prev);
      w_need      = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};
      w_push      = r_exp_active;
      w_pop       = (r_state == ST_GAP) && (r_cnt == HALF_LAST);
      w_next_bit  = r_bit + 4'd1;
      w_busy      = !w_empty || r_exp_active || (r_state != ST_IDLE);
      if (r_pend_e0) begin
         w_push_byte = 8'hE0;
      end else if (r_pend_f0) begin
         w_push_byte = 8'hF0;
      end else begin
         w_push_byte = r_exp_code;
      end
   end

   // Two-flop synchroniser for the sensed bus lines.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_clk_m <= 1'b1;
         r_clk_s <= 1'b1;
         r_dat_m <= 1'b1;
         r_dat_s <= 1'b1;
      end else begin
         r_clk_m <= ps2_clk_i;
         r_clk_s <= r_clk_m;
         r_dat_m <= ps2_data_i;
         r_dat_s <= r_dat_m;
      end
   end

   // Event expander: an event is dropped whole when it cannot fit entirely.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_key_prev   <= ps2_key[10];
         r_exp_active <= 1'b0;
         r_pend_e0    <= 1'b0;
         r_pend_f0    <= 1'b0;
         r_exp_code   <= 8'h00;
         r_overflow   <= 1'b0;
      end else if (w_event) begin
         r_key_prev <= ps2_key[10];
         if (w_free < {{(AW - 1){1'b0}}, w_need}) begin
            r_overflow <= 1'b1;
         end else begin
            r_exp_active <= 1'b1;
            r_pend_e0    <= ps2_key[8];
            r_pend_f0    <= ~ps2_key[9];
            r_exp_code   <= ps2_key[7:0];
         end
      end else if (r_exp_active) begin
         if (r_pend_e0) begin
            r_pend_e0 <= 1'b0;
         end else if (r_pend_f0) begin
            r_pend_f0 <= 1'b0;
         end else begin
            r_exp_active <= 1'b0;
         end
      end
   end

   // FIFO pointers; the extra MSB tells full from empty.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // FIFO byte storage.
   always_ff @(posedge clk) begin
      if (reset_n && w_push) r_mem[r_wptr[AW-1:0]] <= w_push_byte;
   end

   // Transmit FSM; the head byte is only popped once its frame has completed.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_bit    <= 4'd0;
         r_frame  <= 11'h7FF;
         r_clk_o  <= 1'b1;
         r_data_o <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_clk_o  <= 1'b1;
               r_data_o <= 1'b1;
               r_cnt    <= '0;
               if (!w_empty) r_state <= ST_BUSCHK;
            end
            ST_BUSCHK: begin
               if (r_clk_s && r_dat_s) begin
                  if (r_cnt == CHK_LAST) begin
                     r_frame  <= {1'b1, odd_parity(w_head), w_head, 1'b0};
                     r_bit    <= 4'd0;
                     r_cnt    <= '0;
                     r_data_o <= 1'b0;
                     r_clk_o  <= 1'b1;
                     r_state  <= ST_HIGH;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else begin
                  r_cnt <= '0;
               end
            end
            ST_HIGH: begin
               // Early cycles are skipped: our own clock release is still in the synchroniser.
               if (!r_clk_s && (r_cnt >= INH_FIRST) && (r_bit <= 4'd9)) begin
                  r_clk_o  <= 1'b1;
                  r_data_o <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= ST_ABORT;
               end else if (r_cnt == HALF_LAST) begin
                  r_clk_o <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ST_LOW;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_LOW: begin
               if (r_cnt == HALF_LAST) begin
                  r_cnt   <= '0;
                  r_clk_o <= 1'b1;
                  if (r_bit == 4'd10) begin
                     r_data_o <= 1'b1;
                     r_state  <= ST_GAP;
                  end else begin
                     r_bit    <= w_next_bit;
                     r_data_o <= r_frame[w_next_bit];
                     r_state  <= ST_HIGH;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (r_cnt == HALF_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_ABORT: begin
               r_clk_o  <= 1'b1;
               r_data_o <= 1'b1;
               r_cnt    <= '0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_clk_o  <= 1'b1;
               r_data_o <= 1'b1;
               r_cnt    <= '0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   // Registered activity flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= w_busy;
      end
   end

   assign ps2_clk_o  = r_clk_o;
   assign ps2_data_o = r_data_o;
   assign busy       = r_busy;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Directed plus randomized bench: captures frames on ps2_clk_o falling edges
// and compares them with a byte-queue reference of the expected scancodes.
module tb_ps2_key_serializer;
   localparam int HALF_CYC   = 4;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] key_r;
   logic        host_clk, host_data;
   logic        ps2_clk_i, ps2_data_i, ps2_clk_o, ps2_data_o, busy, overflow;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  exp_q[$];
   logic        model_ovf;
   logic [10:0] rx_q[$];
   int          rx_rd = 0;
   int          falls = 0;
   int          abort_gen = 0;
   int          mon_gen = 0;
   int          mon_n = 0;
   logic [10:0] mon_bits;

   always #5 clk = ~clk;

   assign ps2_clk_i  = ps2_clk_o & host_clk;
   assign ps2_data_i = ps2_data_o & host_data;

   ps2_key_serializer #(.HALF_CYC(HALF_CYC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_key   (key_r),
      .ps2_clk_i (ps2_clk_i),
      .ps2_data_i(ps2_data_i),
      .ps2_clk_o (ps2_clk_o),
      .ps2_data_o(ps2_data_o),
      .busy      (busy),
      .overflow  (overflow)
   );

   // Host-side receiver: one sample per falling clock; an abort discards the partial frame.
   always @(negedge ps2_clk_o) begin
      if (mon_gen != abort_gen) begin
         mon_n   = 0;
         mon_gen = abort_gen;
      end
      mon_bits[mon_n] = ps2_data_o;
      mon_n++;
      falls++;
      if (mon_n == 11) begin
         rx_q.push_back(mon_bits);
         mon_n = 0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [10:0] frame_of(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_event(input bit press, input bit ext, input logic [7:0] code);
      int need;
      @(negedge clk);
      key_r = {~key_r[10], press, ext, code};
      need  = 1 + int'(ext) + int'(!press);
      if ((FIFO_DEPTH - exp_q.size()) < need) begin
         model_ovf = 1'b1;
      end else begin
         if (ext)    exp_q.push_back(8'hE0);
         if (!press) exp_q.push_back(8'hF0);
         exp_q.push_back(code);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      repeat (3) @(negedge clk);
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_falls(input int target, input string tag);
      int n;
      n = 0;
      while (falls < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_falls"}, 32'(falls >= target), 32'd1);
   endtask

   task automatic wait_clk_high();
      int n;
      n = 0;
      while (ps2_clk_o !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic drain(input string tag);
      logic [7:0] b;
      check({tag, "_count"}, 32'(rx_q.size() - rx_rd), 32'(exp_q.size()));
      while (exp_q.size() > 0) begin
         b = exp_q.pop_front();
         if (rx_rd < rx_q.size()) begin
            check({tag, "_frame"}, 32'(rx_q[rx_rd]), 32'(frame_of(b)));
            rx_rd++;
         end
      end
      rx_rd = rx_q.size();
      check({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
   endtask

   initial begin
      int t0, t1, base, n, ok;
      bit p, e, p2, e2;
      logic [7:0] c, c2;

      reset_n   = 1'b0;
      key_r     = 11'h000;
      host_clk  = 1'b1;
      host_data = 1'b1;
      model_ovf = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_clk_o", 32'(ps2_clk_o), 32'd1);
      check("rst_data_o", 32'(ps2_data_o), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_frames", 32'(rx_q.size()), 32'd0);

      // make press 0x1C; timing from start-bit drive to busy falling
      send_event(1'b1, 1'b0, 8'h1C);
      t0 = -1;
      t1 = -1;
      for (int i = 0; i < 400 && t1 < 0; i++) begin
         @(negedge clk);
         if (t0 < 0 && ps2_data_o === 1'b0) t0 = i;
         if (t0 >= 0 && busy === 1'b0) t1 = i;
      end
      check("t1_span", 32'((t1 - t0) >= 92 && (t1 - t0) <= 93), 32'd1);
      check("t1_literal", 32'(rx_q.size() > rx_rd ? rx_q[rx_rd] : 11'h000), 32'(11'b10000111000));
      drain("t1");

      // extended release 0x74 -> E0 F0 74
      send_event(1'b0, 1'b1, 8'h74);
      wait_idle("t2");
      drain("t2");

      // bus held busy; third event must be dropped
      host_data = 1'b0;
      send_event(1'b0, 1'b1, 8'h74);
      repeat (6) @(negedge clk);
      send_event(1'b1, 1'b0, 8'h1C);
      repeat (6) @(negedge clk);
      send_event(1'b1, 1'b1, 8'h11);
      repeat (10) @(negedge clk);
      check("t3_ovf", 32'(overflow), 32'(model_ovf));
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_no_tx", 32'(rx_q.size() - rx_rd), 32'd0);
      host_data = 1'b1;
      wait_idle("t3");
      drain("t3");

      // host inhibit during the HIGH phase of bit 5
      send_event(1'b1, 1'b0, 8'h1C);
      base = falls;
      wait_falls(base + 5, "t4");
      wait_clk_high();
      host_clk = 1'b0;
      ok = 1;
      repeat (6) begin
         @(negedge clk);
         if (ps2_clk_o !== 1'b1 || ps2_data_o !== 1'b1) ok = 0;
      end
      abort_gen++;
      check("t4_released", 32'(ok), 32'd1);
      check("t4_abort_falls", 32'(falls - base), 32'd5);
      check("t4_busy_held", 32'(busy), 32'd1);
      repeat (10) @(negedge clk);
      check("t4_quiet", 32'(falls - base), 32'd5);
      host_clk = 1'b1;
      n = 0;
      while (ps2_data_o !== 1'b0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("t4_retx_delay", 32'(n >= 9 && n <= 11), 32'd1);
      wait_idle("t4");
      drain("t4");

      // reset in the middle of bit 3
      send_event(1'b1, 1'b0, 8'h5A);
      base = falls;
      wait_falls(base + 3, "t5");
      wait_clk_high();
      check("t5_ovf_sticky", 32'(overflow), 32'd1);
      @(negedge clk);
      key_r[10] = 1'b1;
      reset_n   = 1'b0;
      @(negedge clk);
      check("t5_clk_o", 32'(ps2_clk_o), 32'd1);
      check("t5_data_o", 32'(ps2_data_o), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_ovf", 32'(overflow), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      abort_gen++;
      exp_q.delete();
      model_ovf = 1'b0;
      rx_rd = rx_q.size();
      base = falls;
      repeat (80) @(negedge clk);
      check("t5_idle_busy", 32'(busy), 32'd0);
      check("t5_no_frame", 32'(falls - base), 32'd0);

      // two events two cycles apart
      send_event(1'b1, 1'b0, 8'h1C);
      @(negedge clk);
      send_event(1'b0, 1'b0, 8'h1C);
      wait_idle("t6");
      drain("t6");

      // randomized events, sometimes in quick pairs (may overflow the 4-byte FIFO)
      for (int it = 0; it < 8; it++) begin
         p = 1'($urandom_range(0, 1));
         e = 1'($urandom_range(0, 1));
         c = 8'($urandom_range(0, 255));
         send_event(p, e, c);
         if ($urandom_range(0, 1) == 1) begin
            p2 = 1'($urandom_range(0, 1));
            e2 = 1'($urandom_range(0, 1));
            c2 = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 3)) @(negedge clk);
            send_event(p2, e2, c2);
         end
         wait_idle("rnd");
         drain("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ps2_key_serializer.md
Name: ps2_key_serializer

Overview:
- Converts the 11-bit `ps2_key` event word delivered by `hps_io` into a PS/2 device-to-host serial stream (clock + data, open-drain model).
- Lets cores that expect a physical PS/2 keyboard line consume OSD/HPS keyboard events.
- Sits between `hps_io` and the core's PS/2 host receiver, in `clk_sys`.
- Expands each event into its scancode byte sequence (E0 prefix, F0 break) and buffers the bytes in a FIFO.
- Honours host clock inhibit with abort and retransmit.

Parameters:
- HALF_CYC, 2000, `clk` cycles per PS/2 clock half-period (>=4).
- FIFO_DEPTH, 8, byte FIFO depth; power of 2, >=4.

Ports:
- clk  in  1  system clock (`clk_sys`).
- reset_n  in  1  synchronous active-low reset.
- ps2_key  in  11  [10] event toggle, [9] 1=press/0=release, [8] extended, [7:0] scancode.
- ps2_clk_i  in  1  sensed PS/2 clock line (asynchronous).
- ps2_data_i  in  1  sensed PS/2 data line (asynchronous).
- ps2_clk_o  out  1  clock drive; 0 = pull low, 1 = release.
- ps2_data_o  out  1  data drive; 0 = pull low, 1 = release.
- busy  out  1  FIFO non-empty or frame in progress.
- overflow  out  1  sticky; an event was dropped for lack of FIFO space.

Behaviour:
- Reset: `ps2_clk_o` = 1, `ps2_data_o` = 1, `busy` = 0, `overflow` = 0, FIFO empty, transmit FSM in IDLE.
  - Reset also loads `key_prev` <= `ps2_key[10]`, so no event fires on release.
  - `overflow` clears only on reset.
- Event detect: an event is `ps2_key[10]` != `key_prev`.
  - Sampled only while the expander is idle; `key_prev` updates on acceptance.
  - A toggle arriving during expansion is accepted on the first idle cycle afterwards.
- Expander: on acceptance, `need` = 1 + `ps2_key[8]` + `~ps2_key[9]`. Fields are latched at acceptance.
  - If free slots < `need`: drop the whole event, set `overflow`, push nothing.
  - Otherwise push one byte per cycle in this order: E0 (if extended), F0 (if release), code.
  - Partial sequences are never enqueued.
- FIFO: pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle are legal.
  - Pop happens only after a frame completes successfully.
- Input sync: `ps2_clk_i` and `ps2_data_i` pass through a 2-flop synchroniser before any use.
- Transmit FSM states:
  - IDLE:
    - FIFO non-empty -> BUSCHK with counter cleared.
  - BUSCHK:
    - Counts cycles while synced clk = 1 and data = 1.
    - Any 0 resets the count.
    - Count reaching 2*HALF_CYC -> load frame, bit index 0, go to HIGH.
  - Frame: 11 bits, sent in order:
    - start bit 0;
    - `data[0]`..`data[7]`, LSB first;
    - odd parity `~^data`;
    - stop bit 1.
  - HIGH:
    - `ps2_data_o` = current bit; `ps2_clk_o` = 1 for HALF_CYC cycles, then go to LOW.
    - Inhibit: synced clk = 0 at any cycle >= 3 of HIGH while bit index <= 9 -> ABORT.
  - LOW:
    - `ps2_clk_o` = 0 for HALF_CYC cycles; data is held.
    - Then: if bit index = 10, go to GAP; otherwise increment the index and go to HIGH.
  - GAP:
    - Both outputs released for HALF_CYC cycles.
    - Then pop the FIFO head and go to IDLE.
  - ABORT:
    - Release both outputs immediately; the head byte is retained; go to IDLE (the retransmit starts with BUSCHK).
    - Inhibit during bit 10 (stop) is ignored; that byte counts as delivered.
- `busy` = FIFO non-empty | expander active | FSM != IDLE.
- Reset mid-frame: outputs return to 1 in the next cycle; the FIFO is flushed; the partial byte is lost.

Test Plan:
1. HALF_CYC=4.
   - Stimulus: toggle `ps2_key[10]` with [9]=1, [8]=0, code=0x1C.
   - Required: one frame, sampled on `ps2_clk_o` falling edges: 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
   - Required: frame + GAP spans 11*8+4 = 92 cycles after BUSCHK; `busy` falls afterward.
2. Stimulus: extended release, code=0x74 ([9]=0, [8]=1).
   - Required: bytes E0 (parity 0), F0 (parity 1), 74 (parity 1), back-to-back with GAP + BUSCHK between them.
3. FIFO_DEPTH=4, lines held busy (`ps2_data_i`=0).
   - Stimulus: first, extended release 0x74 -> 3 bytes queued.
   - Stimulus: then, press 0x1C -> fits, 4 bytes queued.
   - Stimulus: then, extended press 0x11 -> dropped; `overflow`=1.
   - Required: after the lines are released, exactly E0 F0 74 1C is emitted.
4. Inhibit: pull `ps2_clk_i` low during the HIGH phase of bit 5 of byte 0x1C.
   - Required: both outputs go to 1 within 3 cycles; the FIFO head is unchanged.
   - Required: after 8 idle cycles, the full 0x1C frame is retransmitted.
5. Stimulus: assert `reset_n`=0 during bit 3 of a frame.
   - Required: `ps2_clk_o`/`ps2_data_o` = 1, `busy`=0, `overflow`=0.
   - Required: no frame follows release of reset, even with `ps2_key[10]`=1 held throughout.
6. Stimulus: two events toggled 2 cycles apart (press 0x1C, then release 0x1C).
   - Required: both are accepted, emitted in order as 1C, F0, 1C.
